// File: rtl/data_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_if
// Brief    : Request/response bundle between memory_access and the data RAM.
// Revision : 1.0
// ============================================================================
interface data_mem_if #(
    parameter int ERR_CNT_W = 8
) ();
    logic [31:0]          i_data_addr;
    logic [31:0]          i_data_wr;
    logic [1:0]           i_data_rd_en_ctrl;
    logic                 i_data_rd_en;
    logic                 i_data_wr_en;
    logic                 i_err_clr;
    logic [31:0]          o_data_rd;
    logic                 o_misalign;
    logic                 o_oob;
    logic [ERR_CNT_W-1:0] o_err_cnt;
    logic                 o_data_busy;

    modport master (
        output i_data_addr, i_data_wr, i_data_rd_en_ctrl, i_data_rd_en,
               i_data_wr_en, i_err_clr,
        input  o_data_rd, o_misalign, o_oob, o_err_cnt, o_data_busy
    );

    modport slave (
        input  i_data_addr, i_data_wr, i_data_rd_en_ctrl, i_data_rd_en,
               i_data_wr_en, i_err_clr,
        output o_data_rd, o_misalign, o_oob, o_err_cnt, o_data_busy
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Byte-lane data RAM slave with sticky fault status and saturating
//            error counter. Optional DMEM_MISALIGN_SPLIT_EN services
//            misaligned half/word accesses as two word accesses.
// Revision : 1.0
// ============================================================================
module data_mem_responder #(
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          READ_LATENCY = 0,
    parameter int          ERR_CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    data_mem_if.slave  bus
);
    localparam int          c_AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_SPAN = 33'(DEPTH_WORDS) << 2;

    logic [31:0]          mem [DEPTH_WORDS];
    logic [31:0]          w_off;
    logic [c_AW-1:0]      w_idx;
    logic [c_AW-1:0]      w_idx_nxt;
    logic [1:0]           w_lane;
    logic                 w_is_byte;
    logic                 w_is_half;
    logic                 w_req;
    logic                 w_in_range;
    logic                 w_misaligned;
    logic                 w_mis_fault;
    logic                 w_oob_fault;
    logic                 w_fault;
    logic                 w_second;
    logic                 w_busy;
    logic [7:0]           w_mask8;
    logic [63:0]          w_data64;
    logic [31:0]          w_lo_word;
    logic [31:0]          w_hi_word;
    logic [31:0]          w_rd_sh;
    logic [31:0]          w_rd_sized;
    logic [31:0]          w_rd_data;
    logic [c_AW-1:0]      w_wr_idx;
    logic [3:0]           w_wr_mask;
    logic [31:0]          w_wr_word;
    logic                 w_wr_go;
    logic                 r_misalign;
    logic                 r_oob;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    assign w_off        = bus.i_data_addr - BASE_ADDR;
    assign w_idx        = w_off[c_AW+1:2];
    assign w_idx_nxt    = w_idx + c_AW'(1);
    assign w_lane       = w_off[1:0];
    assign w_is_byte    = (bus.i_data_rd_en_ctrl == 2'b00);
    assign w_is_half    = (bus.i_data_rd_en_ctrl == 2'b01);
    assign w_req        = bus.i_data_rd_en | bus.i_data_wr_en;
    assign w_in_range   = (bus.i_data_addr >= BASE_ADDR) && ({1'b0, w_off} < c_SPAN);
    assign w_misaligned = (w_is_half && w_lane[0]) ||
                          (bus.i_data_rd_en_ctrl[1] && (w_lane != 2'b00));

`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_SECOND = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_lo_word;
    logic        w_cross_top;

    // A split access whose second word falls past the last word is out of range.
    assign w_cross_top = w_misaligned && (w_idx == {c_AW{1'b1}});
    assign w_mis_fault = 1'b0;
    assign w_oob_fault = !w_in_range || w_cross_top;
    assign w_second    = (r_state == c_SECOND);
    assign w_busy      = w_req && w_misaligned && !w_oob_fault && !w_second;
    assign w_lo_word   = w_second ? r_lo_word : mem[w_idx];
    assign w_hi_word   = mem[w_idx_nxt];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else if (clk_en) begin
            if (w_busy) begin
                r_state   <= c_SECOND;
                r_lo_word <= mem[w_idx];
            end else begin
                r_state   <= c_IDLE;
            end
        end
    end
`else
    assign w_mis_fault = w_misaligned;
    assign w_oob_fault = !w_in_range;
    assign w_second    = 1'b0;
    assign w_busy      = 1'b0;
    assign w_lo_word   = mem[w_idx];
    assign w_hi_word   = '0;
`endif

    assign w_fault = w_req && (w_mis_fault || w_oob_fault);

    // Lane mask and store data are built over two words so a split store can
    // take its upper half on the second cycle.
    always_comb begin
        w_mask8 = 8'h0F;
        if (w_is_byte)
            w_mask8 = 8'h01;
        else if (w_is_half)
            w_mask8 = 8'h03;
        w_mask8 = w_mask8 << w_lane;
    end

    assign w_data64  = {32'h0, bus.i_data_wr} << {w_lane, 3'b000};
    assign w_rd_sh   = 32'({w_hi_word, w_lo_word} >> {w_lane, 3'b000});

    always_comb begin
        w_rd_sized = w_rd_sh;
        if (w_is_byte)
            w_rd_sized = {24'h0, w_rd_sh[7:0]};
        else if (w_is_half)
            w_rd_sized = {16'h0, w_rd_sh[15:0]};
    end

    assign w_rd_data = (bus.i_data_rd_en && !w_fault && !w_busy) ? w_rd_sized : 32'h0;

    assign w_wr_go   = !rst && clk_en && bus.i_data_wr_en && !w_fault;
    assign w_wr_idx  = w_second ? w_idx_nxt      : w_idx;
    assign w_wr_mask = w_second ? w_mask8[7:4]   : w_mask8[3:0];
    assign w_wr_word = w_second ? w_data64[63:32] : w_data64[31:0];

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_go) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wr_mask[b])
                    mem[w_wr_idx][8*b +: 8] <= w_wr_word[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
            r_oob      <= 1'b0;
            r_err_cnt  <= '0;
        end else if (clk_en) begin
            if (bus.i_err_clr) begin
                r_misalign <= 1'b0;
                r_oob      <= 1'b0;
                r_err_cnt  <= '0;
            end else begin
                if (w_req && w_mis_fault)
                    r_misalign <= 1'b1;
                if (w_req && w_oob_fault)
                    r_oob <= 1'b1;
                if (w_fault && !(&r_err_cnt))
                    r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_rd_comb
            assign bus.o_data_rd = w_rd_data;
        end else begin : g_rd_reg
            logic [31:0] r_data_rd;

            always_ff @(posedge clk) begin
                if (rst)
                    r_data_rd <= 32'h0;
                else if (clk_en && bus.i_data_rd_en && !w_busy)
                    r_data_rd <= w_rd_data;
            end

            assign bus.o_data_rd = r_data_rd;
        end
    endgenerate

    assign bus.o_misalign  = r_misalign;
    assign bus.o_oob       = r_oob;
    assign bus.o_err_cnt   = r_err_cnt;
    assign bus.o_data_busy = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Directed scoreboard bench; one DUT with combinational read, one
//            with registered read.
// Revision : 1.0
// ============================================================================
module tb_data_mem_responder;
    localparam logic [31:0] c_B = 32'h1000_0000;
    localparam logic [1:0]  c_SB = 2'b00;
    localparam logic [1:0]  c_SH = 2'b01;
    localparam logic [1:0]  c_SW = 2'b10;

    logic clk;
    logic rst;
    logic clk_en;
    int   n_pass;
    int   n_total;
    logic [31:0] sb0[$];
    logic [31:0] sb1[$];
    logic [31:0] hold1;

    data_mem_if #(.ERR_CNT_W(8)) bus0 ();
    data_mem_if #(.ERR_CNT_W(8)) bus1 ();

    data_mem_responder #(.READ_LATENCY(0)) u_dut0 (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus0)
    );

    data_mem_responder #(.READ_LATENCY(1)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_st(input string tag, input logic m, input logic o, input logic [7:0] c);
        chk({tag, "_misalign"}, {31'h0, bus0.o_misalign}, {31'h0, m});
        chk({tag, "_oob"},      {31'h0, bus0.o_oob},      {31'h0, o});
        chk({tag, "_errcnt"},   {24'h0, bus0.o_err_cnt},  {24'h0, c});
    endtask

    task automatic idle_bus1();
        bus1.i_data_addr = '0; bus1.i_data_wr = '0; bus1.i_data_rd_en_ctrl = '0;
        bus1.i_data_rd_en = 1'b0; bus1.i_data_wr_en = 1'b0; bus1.i_err_clr = 1'b0;
    endtask

    task automatic idle_bus0();
        bus0.i_data_addr = '0; bus0.i_data_wr = '0; bus0.i_data_rd_en_ctrl = '0;
        bus0.i_data_rd_en = 1'b0; bus0.i_data_wr_en = 1'b0; bus0.i_err_clr = 1'b0;
    endtask

    // Combinational-read DUT: read data is compared mid low phase of the same cycle.
    task automatic cyc0(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                        input logic rd, input logic wr, input logic clr,
                        input logic [31:0] exp, input string tag);
        logic [31:0] e;
        @(negedge clk);
        bus0.i_data_addr = a; bus0.i_data_wr = d; bus0.i_data_rd_en_ctrl = sz;
        bus0.i_data_rd_en = rd; bus0.i_data_wr_en = wr; bus0.i_err_clr = clr;
        idle_bus1();
        if (rd) sb0.push_back(exp);
        #2;
        if (rd) begin
            e = sb0.pop_front();
            chk(tag, bus0.o_data_rd, e);
        end
        @(posedge clk);
        #1;
    endtask

    // Registered-read DUT: output must hold before the edge and update after it.
    task automatic cyc1(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                        input logic rd, input logic wr,
                        input logic [31:0] exp, input string tag);
        logic [31:0] e;
        @(negedge clk);
        bus1.i_data_addr = a; bus1.i_data_wr = d; bus1.i_data_rd_en_ctrl = sz;
        bus1.i_data_rd_en = rd; bus1.i_data_wr_en = wr; bus1.i_err_clr = 1'b0;
        idle_bus0();
        if (rd) sb1.push_back(exp);
        #2;
        chk({tag, "_hold"}, bus1.o_data_rd, hold1);
        @(posedge clk);
        #1;
        if (rd) begin
            e = sb1.pop_front();
            chk(tag, bus1.o_data_rd, e);
            hold1 = e;
        end else begin
            chk({tag, "_keep"}, bus1.o_data_rd, hold1);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        hold1   = 32'h0;
        rst     = 1'b1;
        clk_en  = 1'b1;
        idle_bus0();
        idle_bus1();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd0", bus0.o_data_rd, 32'h0);
        chk("rst_rd1", bus1.o_data_rd, 32'h0);
        chk_st("rst", 1'b0, 1'b0, 8'd0);
        rst = 1'b0;

        cyc0(c_B,     32'hCAFE_BABE, c_SW, 0, 1, 0, 32'h0,         "st_w0");
        cyc0(c_B,     32'h0,         c_SW, 1, 0, 0, 32'hCAFE_BABE, "ld_w0");
        chk_st("ld_w0", 1'b0, 1'b0, 8'd0);
        cyc0(c_B + 4, 32'h1122_3344, c_SW, 0, 1, 0, 32'h0,         "st_w1");
        cyc0(c_B + 5, 32'h0000_0080, c_SB, 0, 1, 0, 32'h0,         "st_b5");
        cyc0(c_B + 4, 32'h0,         c_SW, 1, 0, 0, 32'h1122_8044, "ld_w1");
        cyc0(c_B + 5, 32'h0,         c_SB, 1, 0, 0, 32'h0000_0080, "ld_b5");
        cyc0(c_B + 6, 32'h0000_BEEF, c_SH, 0, 1, 0, 32'h0,         "st_h6");
        cyc0(c_B + 4, 32'h0,         c_SW, 1, 0, 0, 32'hBEEF_8044, "ld_w1b");
        cyc0(c_B + 4, 32'h0,         c_SH, 1, 0, 0, 32'h0000_8044, "ld_h4");
        cyc0(c_B + 7, 32'h0,         c_SB, 1, 0, 0, 32'h0000_00BE, "ld_b7");
        cyc0(c_B,     32'h0,         2'b11, 1, 0, 0, 32'hCAFE_BABE, "ld_sz3");

        // Misaligned half with a concurrent store
        cyc0(c_B + 3, 32'hFFFF_FFFF, c_SH, 1, 1, 0, 32'h0,         "mis_h3");
        chk_st("mis_h3", 1'b1, 1'b0, 8'd1);
        cyc0(c_B,     32'h0,         c_SW, 1, 0, 0, 32'hCAFE_BABE, "mis_ram_keep");
        cyc0(32'h0,   32'h0,         c_SB, 0, 0, 1, 32'h0,         "clr1");
        chk_st("clr1", 1'b0, 1'b0, 8'd0);

        // Out of range below base and at the top
        cyc0(32'h0FFF_FFFC, 32'h0,   c_SW, 1, 0, 0, 32'h0,         "oob_ld");
        chk_st("oob_ld", 1'b0, 1'b1, 8'd1);
        cyc0(c_B + 32'h1000, 32'h1234_5678, c_SW, 0, 1, 0, 32'h0,  "oob_st");
        chk_st("oob_st", 1'b0, 1'b1, 8'd2);
        cyc0(c_B,     32'h0,         c_SW, 1, 0, 0, 32'hCAFE_BABE, "oob_alias_keep");

        cyc0(32'h0,   32'h0,         c_SB, 0, 0, 1, 32'h0,         "clr2");
        cyc0(c_B + 32'h1001, 32'h0,  c_SW, 1, 0, 0, 32'h0,         "both");
        chk_st("both", 1'b1, 1'b1, 8'd1);
        cyc0(c_B + 3, 32'h0,         c_SH, 1, 0, 1, 32'h0,         "clr_win");
        chk_st("clr_win", 1'b0, 1'b0, 8'd0);

        for (int i = 0; i < 300; i++)
            cyc0(c_B + 32'h1000, 32'h0, c_SW, 1, 0, 0, 32'h0, "sat_rd");
        chk_st("sat", 1'b0, 1'b1, 8'd255);

        // Global enable low: neither store nor clear takes effect
        clk_en = 1'b0;
        cyc0(c_B,     32'hDEAD_BEEF, c_SW, 0, 1, 1, 32'h0,         "ce0_st");
        chk_st("ce0", 1'b0, 1'b1, 8'd255);
        clk_en = 1'b1;
        cyc0(c_B,     32'h0,         c_SW, 1, 0, 0, 32'hCAFE_BABE, "ce0_keep");

        // Registered-read DUT
        cyc1(c_B + 16, 32'hA5A5_0001, c_SW, 0, 1, 32'h0,         "l1_st");
        cyc1(c_B + 16, 32'h0,         c_SW, 1, 0, 32'hA5A5_0001, "l1_ld");
        cyc1(32'h0,    32'h0,         c_SW, 0, 0, 32'h0,         "l1_idle");
        cyc1(c_B + 16, 32'h5A5A_0002, c_SW, 1, 1, 32'hA5A5_0001, "l1_rbw");
        cyc1(c_B + 16, 32'h0,         c_SW, 1, 0, 32'h5A5A_0002, "l1_new");
        cyc1(c_B + 19, 32'h0,         c_SB, 1, 0, 32'h0000_005A, "l1_b19");
        cyc1(c_B + 3,  32'h0,         c_SH, 1, 0, 32'h0,         "l1_fault");
        cyc1(c_B + 16, 32'h0,         c_SW, 1, 0, 32'h5A5A_0002, "l1_pre");

        // Reset mid-stream clears outputs but not RAM
        rst = 1'b1;
        cyc0(32'h0,   32'h0,         c_SB, 0, 0, 0, 32'h0,         "rst_mid");
        rst = 1'b0;
        chk_st("rst_mid", 1'b0, 1'b0, 8'd0);
        chk("rst_mid_rd1", bus1.o_data_rd, 32'h0);
        hold1 = 32'h0;
        cyc0(c_B + 4,  32'h0, c_SW, 1, 0, 0, 32'hBEEF_8044, "rst_keep0");
        cyc1(c_B + 16, 32'h0, c_SW, 1, 0,    32'h5A5A_0002, "rst_keep1");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory slave at the far end of the memory_access data port.
- Accepts read/write requests with address, size and store data. Performs byte-lane-steered writes into an internal word-organised RAM. Returns load data right-justified for the memory_access stage to sign- or zero-extend.
- Sticky misalignment and out-of-range status plus a saturating error counter for the debug/CSR path.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM (power of two).
- BASE_ADDR, 32'h1000_0000, byte address of word 0.
- READ_LATENCY, 0, 0 = asynchronous read (data valid same cycle as request); 1 = registered read (data valid one cycle after request).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  global enable; when 0 no state changes and all registered outputs hold.
- i_data_addr  in  32  byte address.
- i_data_wr  in  32  store data, right-justified.
- i_data_rd_en_ctrl  in  2  size: 00 byte, 01 half, 10 word, 11 treated as word.
- i_data_rd_en  in  1  load request.
- i_data_wr_en  in  1  store request.
- o_data_rd  out  32  load data, right-justified; unused upper bits 0.
- o_misalign  out  1  sticky: a misaligned access was seen.
- o_oob  out  1  sticky: an out-of-range access was seen.
- o_err_cnt  out  ERR_CNT_W  saturating count of faulting accesses.
- i_err_clr  in  1  clears o_misalign, o_oob and o_err_cnt.

Behaviour:
- Reset (rst=1 at edge):
  - o_data_rd, o_misalign, o_oob and o_err_cnt go to 0.
  - RAM contents are not cleared.
  - The READ_LATENCY=1 pipeline register is cleared.
  - rst has priority over clk_en.
- Decode:
  - off = addr - BASE_ADDR; word index = off[log2(DEPTH_WORDS)+1:2]; lane = off[1:0].
  - In range when addr >= BASE_ADDR and off < 4*DEPTH_WORDS.
  - Misaligned when size=half and lane[0]=1, or when size=word and lane!=0.
- Writes (i_data_wr_en=1, clk_en=1, in range, aligned):
  - Byte: i_data_wr[7:0] is written to byte lane `lane`.
  - Half: i_data_wr[15:0] is written to lanes {lane[1],0} and {lane[1],1}.
  - Word: all four lanes are written.
  - Non-selected lanes are unchanged.
- Reads (right-justification):
  - Byte: the lane byte goes to o_data_rd[7:0]; bits [31:8] are 0.
  - Half: the half goes to [15:0]; bits [31:16] are 0.
  - Word: the full word.
  - No sign extension here; memory_access does it.
- Read timing:
  - READ_LATENCY=0: o_data_rd is combinational from the current request. It is 0 when i_data_rd_en=0 or the access faults.
  - READ_LATENCY=1: o_data_rd is registered at the edge on which the request is sampled. It holds until the next accepted read, and updates only when clk_en=1.
- Simultaneous rd and wr to the same word: read-before-write. The read returns the pre-store value; the store completes at the same edge.
- Faulting access (request asserted, out of range or misaligned):
  - The store is suppressed and read data is 0.
  - The relevant sticky flag is set at the edge.
  - o_err_cnt increments by 1 per faulting cycle and saturates at all-ones with no wrap.
  - An access that is both misaligned and out of range sets both flags but counts once.
- i_err_clr at the same edge as a fault: the clear wins, and the flags and counter end at 0.
- Neither enable asserted: no RAM access and no status change.

Optional Feature:
- Macro: DMEM_MISALIGN_SPLIT_EN.
- Defined:
  - A misaligned half or word access is not a fault.
  - It is serviced as two word accesses over two cycles; the memory stalls the request for one cycle via an internal 2-state FSM (IDLE -> SECOND -> IDLE).
  - An added output o_data_busy is high during the first cycle; the requester must hold inputs while it is high.
  - Data is stitched from the two words.
  - A split access that crosses the top of the range sets o_oob.
- Undefined:
  - Misaligned accesses fault as above.
  - o_data_busy is tied 0.

Test Plan:
- Word store 32'hCAFEBABE to 32'h1000_0000, then word load from the same address -> o_data_rd=32'hCAFEBABE; no flags set.
- Byte store 8'h80 to 32'h1000_0005 over an existing word 32'h1122_3344, then word load -> 32'h1122_8044; byte load of 32'h1000_0005 -> 32'h0000_0080.
- Half load at 32'h1000_0003 -> o_misalign=1, o_err_cnt=1, data 0, and RAM is unchanged by a concurrent store; i_err_clr -> all cleared next edge.
- Load from 32'h0FFF_FFFC and a store to BASE+4*DEPTH_WORDS -> o_oob=1, store ignored, o_err_cnt=2; 300 faults with ERR_CNT_W=8 -> count 255.
- READ_LATENCY=1: load request at cycle N -> data at cycle N+1. Same-cycle rd+wr to one word -> old value returned, new value visible on the next read.
- clk_en=0 with a store request -> RAM unchanged; rst asserted mid-stream -> outputs 0 next edge, and RAM data is preserved on a later read.
